// File: rtl/alloc_pkg.sv
// Shared definitions for the slot allocator: search-mode encodings and index width helper.
package alloc_pkg;

    localparam int unsigned ALLOC_LOWEST = 0;
    localparam int unsigned ALLOC_RR     = 1;

    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/free_slot_finder.sv
// Combinational search for the first free slot, either from index 0 or rotating from a start
// pointer with wrap-around.
module free_slot_finder import alloc_pkg::*; #(
    parameter int unsigned N  = 8,
    parameter int unsigned RR = ALLOC_LOWEST,
    parameter int unsigned W  = idx_w(N)
) (
    input  logic [N-1:0] used,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    localparam logic [W:0] NW = (W+1)'(N);

    logic [W-1:0] base;
    logic [W:0]   cand;

    assign base = (RR == ALLOC_RR) ? start : '0;

    // Walk offsets from the top down so the smallest offset from base wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, base} + (W+1)'(k);
            if (cand >= NW) begin
                cand = cand - NW;
            end
            if (!used[cand[W-1:0]]) begin
                found = 1'b1;
                idx   = cand[W-1:0];
            end
        end
    end

endmodule

// File: rtl/slot_allocator.sv
// Free-slot allocator: bitmap of buffer slots, registered one-per-cycle offer over valid/ready,
// slot release with double-free / out-of-range error pulse, occupancy count and flush.
module slot_allocator import alloc_pkg::*; #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned IDX_W     = idx_w(NUM_SLOTS),
    parameter int unsigned RR_MODE   = ALLOC_LOWEST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic             alloc_vld,
    input  logic             alloc_rdy,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             rel_vld,
    input  logic [IDX_W-1:0] rel_idx,
    output logic [IDX_W:0]   free_cnt,
    output logic             full,
    output logic             err_rel
);

    localparam logic [IDX_W:0]   NUM_CNT  = (IDX_W+1)'(NUM_SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    logic [NUM_SLOTS-1:0] used_q, used_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W:0]       free_cnt_q, free_cnt_d;
    logic                 alloc_vld_q;
    logic [IDX_W-1:0]     alloc_idx_q;
    logic                 err_rel_q, err_rel_d;
    logic                 fire, rel_ok;
    logic                 found;
    logic [IDX_W-1:0]     found_idx;

    always_comb begin
        fire   = alloc_vld_q & alloc_rdy;
        rel_ok = 1'b0;
        used_d = used_q;
        // Only indices below NUM_SLOTS can match, so out-of-range releases fall out as errors.
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (rel_vld && rel_idx == IDX_W'(i) && used_q[i]) begin
                rel_ok = 1'b1;
            end
        end
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (fire && alloc_idx_q == IDX_W'(i)) begin
                used_d[i] = 1'b1;
            end
            if (rel_ok && rel_idx == IDX_W'(i)) begin
                used_d[i] = 1'b0;
            end
        end
        free_cnt_d = free_cnt_q - (IDX_W+1)'(fire) + (IDX_W+1)'(rel_ok);
        err_rel_d  = rel_vld & ~rel_ok;
        ptr_d      = ptr_q;
        if (RR_MODE == ALLOC_RR && fire) begin
            ptr_d = (alloc_idx_q == LAST_IDX) ? '0 : alloc_idx_q + IDX_W'(1);
        end
        if (flush) begin
            used_d     = '0;
            ptr_d      = '0;
            free_cnt_d = NUM_CNT;
            err_rel_d  = 1'b0;
        end
    end

    free_slot_finder #(
        .N  (NUM_SLOTS),
        .RR (RR_MODE),
        .W  (IDX_W)
    ) u_finder (
        .used  (used_d),
        .start (ptr_d),
        .found (found),
        .idx   (found_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q      <= '0;
            ptr_q       <= '0;
            free_cnt_q  <= NUM_CNT;
            alloc_vld_q <= 1'b1;
            alloc_idx_q <= '0;
            err_rel_q   <= 1'b0;
        end else begin
            used_q      <= used_d;
            ptr_q       <= ptr_d;
            free_cnt_q  <= free_cnt_d;
            alloc_vld_q <= found;
            alloc_idx_q <= found ? found_idx : '0;
            err_rel_q   <= err_rel_d;
        end
    end

    assign alloc_vld = alloc_vld_q;
    assign alloc_idx = alloc_idx_q;
    assign free_cnt  = free_cnt_q;
    assign full      = (free_cnt_q == '0);
    assign err_rel   = err_rel_q;

endmodule

// File: tb/tb_slot_allocator.sv
// Bench for slot_allocator: a lowest-first and a round-robin instance share stimulus; directed
// vector table, hand sequences, and a randomized run against an array-based model.
module tb_slot_allocator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       alloc_rdy = 1'b0;
    logic       rel_vld = 1'b0;
    logic [2:0] rel_idx = '0;

    logic       lo_vld, lo_full, lo_err, rr_vld, rr_full, rr_err;
    logic [2:0] lo_idx, rr_idx;
    logic [3:0] lo_cnt, rr_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    slot_allocator #(.NUM_SLOTS(8), .RR_MODE(0)) u_lo (
        .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_vld(lo_vld), .alloc_rdy(alloc_rdy),
        .alloc_idx(lo_idx), .rel_vld(rel_vld), .rel_idx(rel_idx), .free_cnt(lo_cnt),
        .full(lo_full), .err_rel(lo_err)
    );

    slot_allocator #(.NUM_SLOTS(8), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_vld(rr_vld), .alloc_rdy(alloc_rdy),
        .alloc_idx(rr_idx), .rel_vld(rel_vld), .rel_idx(rel_idx), .free_cnt(rr_cnt),
        .full(rr_full), .err_rel(rr_err)
    );

    typedef struct {
        bit rdy; bit rv; int ri; bit fl;
        bit vld; int idx; int cnt; bit err;
    } vec_t;

    vec_t tbl[$];

    // Reference model state, indexed [0] = lowest-first, [1] = round-robin.
    bit mu[2][8];
    int mptr[2];
    int mcnt[2];
    bit merr[2];
    bit mvld[2];
    int midx[2];

    task automatic cmp(string name, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_out(string name, int m, bit ev, int ei, int ec, bit ee);
        cmp({name, ".vld"},  m ? int'(rr_vld)  : int'(lo_vld),  int'(ev));
        cmp({name, ".idx"},  m ? int'(rr_idx)  : int'(lo_idx),  ei);
        cmp({name, ".cnt"},  m ? int'(rr_cnt)  : int'(lo_cnt),  ec);
        cmp({name, ".full"}, m ? int'(rr_full) : int'(lo_full), int'(ec == 0));
        cmp({name, ".err"},  m ? int'(rr_err)  : int'(lo_err),  int'(ee));
    endtask

    task automatic add(bit rdy, bit rv, int ri, bit fl, bit vld, int idx, int cnt, bit err);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.ri = ri; v.fl = fl;
        v.vld = vld; v.idx = idx; v.cnt = cnt; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; alloc_rdy = 1'b0; rel_vld = 1'b0; rel_idx = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step(bit rdy, bit rv, int ri, bit fl);
        alloc_rdy = rdy; rel_vld = rv; rel_idx = 3'(ri); flush = fl;
        @(posedge clk);
        #1;
        alloc_rdy = 1'b0; rel_vld = 1'b0; flush = 1'b0;
    endtask

    task automatic model_offer(int m);
        int j;
        mvld[m] = 1'b0;
        midx[m] = 0;
        mcnt[m] = 0;
        for (int i = 0; i < 8; i++) if (!mu[m][i]) mcnt[m]++;
        for (int k = 0; k < 8; k++) begin
            j = (m == 1) ? (mptr[m] + k) % 8 : k;
            if (!mu[m][j]) begin
                mvld[m] = 1'b1;
                midx[m] = j;
                break;
            end
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 8; i++) mu[m][i] = 1'b0;
            mptr[m] = 0;
            merr[m] = 1'b0;
            model_offer(m);
        end
    endtask

    task automatic model_step(bit rdy, bit rv, int ri, bit fl);
        bit fire, ok;
        for (int m = 0; m < 2; m++) begin
            fire = mvld[m] && rdy;
            ok = rv && ri < 8 && mu[m][ri];
            if (fl) begin
                for (int i = 0; i < 8; i++) mu[m][i] = 1'b0;
                mptr[m] = 0;
                merr[m] = 1'b0;
            end else begin
                if (fire) begin
                    mu[m][midx[m]] = 1'b1;
                    if (m == 1) mptr[m] = (midx[m] + 1) % 8;
                end
                if (ok) mu[m][ri] = 1'b0;
                merr[m] = rv && !ok;
            end
            model_offer(m);
        end
    endtask

    initial begin
        bit r_rdy, r_rv, r_fl;
        int r_ri;

        // Lowest-first directed table: fill, release while full, double free,
        // fire+release in one cycle, release of the offered slot, flushes.
        for (int k = 0; k < 7; k++) add(1, 0, 0, 0, 1, k + 1, 7 - k, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 5, 0, 1, 5, 1, 0);
        add(0, 1, 3, 0, 1, 3, 2, 0);
        add(0, 1, 3, 0, 1, 3, 2, 1);
        add(0, 0, 0, 0, 1, 3, 2, 0);
        add(1, 0, 0, 0, 1, 5, 1, 0);
        add(0, 1, 4, 0, 1, 4, 2, 0);
        add(1, 1, 1, 0, 1, 1, 2, 0);
        add(1, 1, 1, 0, 1, 5, 1, 1);
        add(1, 1, 5, 1, 1, 0, 8, 0);
        for (int k = 0; k < 6; k++) add(1, 0, 0, 0, 1, k + 1, 7 - k, 0);
        add(1, 1, 2, 1, 1, 0, 8, 0);

        do_reset();
        check_out("reset_lo", 0, 1, 0, 8, 0);
        check_out("reset_rr", 1, 1, 0, 8, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rdy, tbl[i].rv, tbl[i].ri, tbl[i].fl);
            check_out($sformatf("vec%0d", i), 0, tbl[i].vld, tbl[i].idx, tbl[i].cnt, tbl[i].err);
        end

        // Round-robin: allocate 0..2, free 0, next offer continues at 3 and wraps to 0.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0);
            check_out($sformatf("rr_alloc%0d", k), 1, 1, k + 1, 7 - k, 0);
        end
        step(0, 1, 0, 0);
        check_out("rr_rel0", 1, 1, 3, 6, 0);
        for (int k = 3; k < 8; k++) begin
            step(1, 0, 0, 0);
            check_out($sformatf("rr_fire%0d", k), 1, 1, (k == 7) ? 0 : k + 1, 8 - k, 0);
        end
        step(1, 0, 0, 0);
        check_out("rr_full", 1, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a burst, checked before any clock edge.
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0);
        alloc_rdy = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst_lo", 0, 1, 0, 8, 0);
        check_out("async_rst_rr", 1, 1, 0, 8, 0);
        alloc_rdy = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized run against the model, both instances.
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            r_rdy = ($urandom_range(0, 99) < 60);
            r_rv  = ($urandom_range(0, 99) < 45);
            r_ri  = $urandom_range(0, 7);
            r_fl  = ($urandom_range(0, 99) == 0);
            model_step(r_rdy, r_rv, r_ri, r_fl);
            step(r_rdy, r_rv, r_ri, r_fl);
            for (int m = 0; m < 2; m++)
                check_out($sformatf("rnd%0d_m%0d", c, m), m, mvld[m], midx[m], mcnt[m], merr[m]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
